// File: rtl/pred_rf_pkg.sv
// Shared constants and helpers for the rotating predicate register file.
package pred_rf_pkg;

  localparam int unsigned P_DEPTH    = 16;
  localparam int unsigned P_AW       = 4;
  localparam int unsigned P_NSTATIC  = 8;
  localparam int unsigned P_TRUE_IDX = 0;

  // Number of entries in the rotating region.
  function automatic int unsigned rot_size(input int unsigned depth, input int unsigned nstatic);
    return depth - nstatic;
  endfunction

endpackage

// File: rtl/pred_addr_xlate.sv
// Logical-to-physical predicate address translation through the rotating base.
module pred_addr_xlate #(
  parameter int unsigned aw      = 4,
  parameter int unsigned nstatic = 8,
  parameter int unsigned rw      = 3
) (
  input  logic [aw-1:0] addr,
  input  logic [rw-1:0] rrb,
  output logic [aw-1:0] phys_c
);

  logic [rw-1:0] rot_off;

  // Rotating region size is a power of two, so the modulo is a truncation.
  assign rot_off = rw'(addr - aw'(nstatic) + aw'(rrb));
  assign phys_c  = (addr < aw'(nstatic)) ? addr : aw'(nstatic) + aw'(rot_off);

endmodule

// File: rtl/pred_rotating_regfile.sv
// Predicate register file: two write ports, two registered bypassing read ports,
// rotating region renamed per loop iteration by the rrb base.
module pred_rotating_regfile
  import pred_rf_pkg::*;
#(
  parameter  int unsigned depth   = P_DEPTH,
  parameter  int unsigned aw      = P_AW,
  parameter  int unsigned nstatic = P_NSTATIC,
  localparam int unsigned rw      = $clog2(rot_size(depth, nstatic))
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          w0_enable,
  input  logic [aw-1:0] w0_addr,
  input  logic          w0_data,
  input  logic          w1_enable,
  input  logic [aw-1:0] w1_addr,
  input  logic          w1_data,
  input  logic [aw-1:0] r0_addr,
  input  logic [aw-1:0] r1_addr,
  output logic          r0_data,
  output logic          r1_data,
  input  logic          rotate,
  input  logic          clear,
  output logic [rw-1:0] rrb
);

  localparam logic [depth-1:0] RESET_VEC = depth'(1) << P_TRUE_IDX;

  logic [depth-1:0] pr_q;
  logic [depth-1:0] pr_d;
  logic [aw-1:0]    w0_phys_c;
  logic [aw-1:0]    w1_phys_c;
  logic [aw-1:0]    r0_phys_c;
  logic [aw-1:0]    r1_phys_c;
  logic             r0_d;
  logic             r1_d;

  pred_addr_xlate #(.aw(aw), .nstatic(nstatic), .rw(rw)) u_xlate_w0 (
    .addr(w0_addr), .rrb(rrb), .phys_c(w0_phys_c)
  );
  pred_addr_xlate #(.aw(aw), .nstatic(nstatic), .rw(rw)) u_xlate_w1 (
    .addr(w1_addr), .rrb(rrb), .phys_c(w1_phys_c)
  );
  pred_addr_xlate #(.aw(aw), .nstatic(nstatic), .rw(rw)) u_xlate_r0 (
    .addr(r0_addr), .rrb(rrb), .phys_c(r0_phys_c)
  );
  pred_addr_xlate #(.aw(aw), .nstatic(nstatic), .rw(rw)) u_xlate_r1 (
    .addr(r1_addr), .rrb(rrb), .phys_c(r1_phys_c)
  );

  // Next-state: clear, then port 0, then port 1 (port 1 wins on collision).
  always_comb begin
    pr_d = pr_q;
    if (clear) begin
      pr_d = RESET_VEC;
    end
    if (w0_enable) begin
      pr_d[w0_phys_c] = w0_data;
    end
    if (w1_enable) begin
      pr_d[w1_phys_c] = w1_data;
    end
    pr_d[P_TRUE_IDX] = 1'b1;
  end

  // Reads sample the next state, giving write-through bypass.
  always_comb begin
    r0_d = pr_d[r0_phys_c];
    r1_d = pr_d[r1_phys_c];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pr_q    <= RESET_VEC;
      r0_data <= 1'b0;
      r1_data <= 1'b0;
      rrb     <= '0;
    end else begin
      pr_q    <= pr_d;
      r0_data <= r0_d;
      r1_data <= r1_d;
      if (rotate) begin
        rrb <= rrb - rw'(1);
      end
    end
  end

endmodule

// File: tb/tb_pred_rotating_regfile.sv
// Self-checking bench for pred_rotating_regfile: directed scenarios plus random traffic vs. a behavioural model.
module tb_pred_rotating_regfile;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int NST   = 8;
  localparam int NROT  = DEPTH - NST;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          w0_enable, w0_data, w1_enable, w1_data;
  logic [AW-1:0] w0_addr, w1_addr, r0_addr, r1_addr;
  logic          r0_data, r1_data;
  logic          rotate, clear;
  logic [2:0]    rrb;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit m_mem [DEPTH];
  int m_rrb;
  bit e_r0, e_r1;

  pred_rotating_regfile dut (
    .clk(clk), .reset_n(reset_n),
    .w0_enable(w0_enable), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_enable(w1_enable), .w1_addr(w1_addr), .w1_data(w1_data),
    .r0_addr(r0_addr), .r1_addr(r1_addr),
    .r0_data(r0_data), .r1_data(r1_data),
    .rotate(rotate), .clear(clear), .rrb(rrb)
  );

  always #5 clk = ~clk;

  function automatic int phys(input int a, input int r);
    if (a < NST) return a;
    return NST + ((a - NST + r) % NROT);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 1'b0;
    m_mem[0] = 1'b1;
    m_rrb = 0;
  endtask

  // Apply one clock edge to the model using the currently driven inputs.
  task automatic model_edge();
    bit nxt [DEPTH];
    nxt = m_mem;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) nxt[i] = 1'b0;
    end
    if (w0_enable && w0_addr != 0) nxt[phys(int'(w0_addr), m_rrb)] = w0_data;
    if (w1_enable && w1_addr != 0) nxt[phys(int'(w1_addr), m_rrb)] = w1_data;
    nxt[0] = 1'b1;
    e_r0 = nxt[phys(int'(r0_addr), m_rrb)];
    e_r1 = nxt[phys(int'(r1_addr), m_rrb)];
    m_mem = nxt;
    if (rotate) m_rrb = (m_rrb + NROT - 1) % NROT;
  endtask

  // One clock with the driven inputs; model and DUT compared at the following negedge.
  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check({tag, ".r0"}, 32'(r0_data), 32'(e_r0));
    check({tag, ".r1"}, 32'(r1_data), 32'(e_r1));
    check({tag, ".rrb"}, 32'(rrb), 32'(m_rrb));
  endtask

  task automatic idle();
    w0_enable = 0; w1_enable = 0; rotate = 0; clear = 0;
  endtask

  initial begin
    reset_n = 0;
    w0_enable = 0; w0_addr = '0; w0_data = 0;
    w1_enable = 0; w1_addr = '0; w1_data = 0;
    r0_addr = '0; r1_addr = '0; rotate = 0; clear = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset.r0", 32'(r0_data), 32'd0);
    check("reset.r1", 32'(r1_data), 32'd0);
    check("reset.rrb", 32'(rrb), 32'd0);
    reset_n = 1;

    // Entry 0 reads true, ordinary entry reads 0
    r0_addr = 4'd0; r1_addr = 4'd5;
    cycle("rd0_5");
    check("entry0.r0", 32'(r0_data), 32'd1);
    check("entry5.r1", 32'(r1_data), 32'd0);

    // Write 0 to entry 0 is dropped, including through the bypass path
    w0_enable = 1; w0_addr = 4'd0; w0_data = 0; r0_addr = 4'd0;
    cycle("wr0_bypass");
    check("entry0.bypass", 32'(r0_data), 32'd1);
    idle();
    cycle("wr0_after");
    check("entry0.after", 32'(r0_data), 32'd1);

    // Port 1 wins on a same-entry collision
    w0_enable = 1; w0_addr = 4'd3; w0_data = 1;
    w1_enable = 1; w1_addr = 4'd3; w1_data = 0; r0_addr = 4'd3;
    cycle("prio");
    check("prio.r0", 32'(r0_data), 32'd0);
    idle();
    cycle("prio_hold");
    check("prio.hold", 32'(r0_data), 32'd0);

    // Bypass on read port 1
    w0_enable = 1; w0_addr = 4'd12; w0_data = 1; r1_addr = 4'd12;
    cycle("bypass");
    check("bypass.r1", 32'(r1_data), 32'd1);
    idle();

    // Rotation and wrap
    w0_enable = 1; w0_addr = 4'd8; w0_data = 1;
    cycle("rot_wr8");
    idle(); rotate = 1;
    cycle("rot_pulse");
    check("rot.rrb", 32'(rrb), 32'd7);
    idle(); r0_addr = 4'd9; r1_addr = 4'd8;
    cycle("rot_rd");
    check("rot.l9", 32'(r0_data), 32'd1);
    check("rot.l8", 32'(r1_data), 32'd0);
    r0_addr = 4'd4;
    cycle("rot_static");
    check("rot.l4", 32'(r0_data), 32'd0);

    // Clear combined with a write and a rotate
    w0_enable = 1; w0_addr = 4'd2;  w0_data = 1;
    w1_enable = 1; w1_addr = 4'd9;  w1_data = 1;
    cycle("pre_a");
    w0_addr = 4'd14; w1_enable = 0;
    cycle("pre_b");
    idle(); clear = 1; rotate = 1;
    w0_enable = 1; w0_addr = 4'd5; w0_data = 1;
    cycle("clr_combo");
    check("clr.rrb", 32'(rrb), 32'd6);
    idle();
    for (int a = 0; a < DEPTH; a += 2) begin
      r0_addr = AW'(a); r1_addr = AW'(a + 1);
      cycle("clr_sweep");
      check($sformatf("clr.l%0d", a), 32'(r0_data), 32'((a == 0) || (a == 5)));
      check($sformatf("clr.l%0d", a + 1), 32'(r1_data), 32'((a + 1 == 0) || (a + 1 == 5)));
    end

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      w0_enable = 1'($urandom_range(0, 1));
      w0_addr   = AW'($urandom);
      w0_data   = 1'($urandom);
      w1_enable = 1'($urandom_range(0, 1));
      w1_addr   = ($urandom_range(0, 3) == 0) ? w0_addr : AW'($urandom);
      w1_data   = 1'($urandom);
      r0_addr   = ($urandom_range(0, 2) == 0) ? w0_addr : AW'($urandom);
      r1_addr   = ($urandom_range(0, 2) == 0) ? w1_addr : AW'($urandom);
      rotate    = ($urandom_range(0, 3) == 0);
      clear     = ($urandom_range(0, 19) == 0);
      cycle("rand");
    end

    // Reset asserted mid-operation
    idle(); rotate = 1; r0_addr = 4'd0;
    cycle("pre_rst");
    check("pre_rst.r0", 32'(r0_data), 32'd1);
    idle();
    w0_enable = 1; w0_addr = 4'd7; w0_data = 1;
    #2 reset_n = 0;
    #1;
    check("async_rst.r0", 32'(r0_data), 32'd0);
    check("async_rst.r1", 32'(r1_data), 32'd0);
    check("async_rst.rrb", 32'(rrb), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    model_reset();
    idle(); r0_addr = 4'd7; r1_addr = 4'd0;
    cycle("post_rst");
    check("post_rst.l7", 32'(r0_data), 32'd0);
    check("post_rst.l0", 32'(r1_data), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
